// File: rtl/lookup_table_pp_loader_pkg.sv
`default_nettype none
// ==== lut_pp_pkg : shared types/constants for the ping-pong lookup table ====
// ==== rev 1.0                                                             ====
package lut_pp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BEAT = 2'd2,
    SWAP = 2'd3
  } load_state_t;

  localparam int DEF_AXI_DATA_W = 32;
  localparam int BYTES_PER_BEAT = DEF_AXI_DATA_W / 8;
  localparam int DEF_ADDR_W     = 4;
  // RAM address is {bank, index}: the bank bit sits just above the index.
  localparam int BANK_SEL_BIT   = DEF_ADDR_W;

  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lookup_table_pp_loader_if.sv
`default_nettype none
// ==== lookup_table_pp_loader_if : read-only databus between loader and memory ====
// ==== rev 1.0                                                                  ====
interface lookup_table_pp_loader_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8
);
  logic                    databus_valid_0;
  logic                    databus_ready_0;
  logic [AXI_ADDR_W-1:0]   databus_addr_0;
  logic [AXI_DATA_W-1:0]   databus_rdata_0;
  logic [AXI_DATA_W-1:0]   databus_wdata_0;
  logic [AXI_DATA_W/8-1:0] databus_wstrb_0;
  logic [LEN_W-1:0]        databus_len_0;
  logic                    databus_last_0;

  modport master (
    output databus_valid_0, databus_addr_0, databus_wdata_0,
           databus_wstrb_0, databus_len_0,
    input  databus_ready_0, databus_rdata_0, databus_last_0
  );

  modport slave (
    input  databus_valid_0, databus_addr_0, databus_wdata_0,
           databus_wstrb_0, databus_len_0,
    output databus_ready_0, databus_rdata_0, databus_last_0
  );
endinterface
`default_nettype wire

// File: rtl/lookup_table_pp_loader_loader.sv
`default_nettype none
// ==== lut_burst_loader : splits a table load into databus bursts and writes ====
// ==== each beat into the RAM write port. rev 1.0                            ====
module lut_burst_loader
  import lut_pp_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  disabled,
  input  logic                  ping_pong,
  input  logic                  bank_rd,
  input  logic [AXI_ADDR_W-1:0] ext_addr,
  input  logic [LEN_W-1:0]      length,
  lookup_table_pp_loader_if.master databus,
  output logic [ADDR_W:0]       wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  wr_en,
  output logic                  done,
  output logic                  bank_wr,
  output logic                  swap_en
);

  localparam int CNT_W       = ADDR_W + 1;
  localparam int TABLE_WORDS = 1 << ADDR_W;
  localparam int CAP         = (MAX_BURST < TABLE_WORDS) ? MAX_BURST : TABLE_WORDS;
  localparam logic [CNT_W-1:0]      WORDS_MAX = CNT_W'(TABLE_WORDS);
  localparam logic [CNT_W-1:0]      CAP_C     = CNT_W'(CAP);
  localparam logic [CNT_W-1:0]      ONE       = CNT_W'(1);
  localparam logic [AXI_ADDR_W-1:0] BPB_A     = AXI_ADDR_W'(beat_bytes(AXI_DATA_W));

  load_state_t           state, state_n;
  logic [AXI_ADDR_W-1:0] base, base_n;
  logic [CNT_W-1:0]      remaining, remaining_n;
  logic [CNT_W-1:0]      beats_done, beats_done_n;
  logic [CNT_W-1:0]      burst_len, burst_len_n;
  logic [CNT_W-1:0]      burst_cnt, burst_cnt_n;
  logic                  pp, pp_n;
  logic                  bank_wr_n;
  logic                  valid, valid_n;
  logic [AXI_ADDR_W-1:0] req_addr, req_addr_n;
  logic [LEN_W-1:0]      req_len, req_len_n;
  logic                  done_n;
  logic [CNT_W-1:0]      words_clamped;
  logic [CNT_W-1:0]      burst_now;
  logic                  unused_last;

  assign unused_last   = databus.databus_last_0;
  assign words_clamped = (int'(length) > TABLE_WORDS) ? WORDS_MAX : CNT_W'(length);
  assign burst_now     = (remaining > CAP_C) ? CAP_C : remaining;

  assign databus.databus_valid_0 = valid;
  assign databus.databus_addr_0  = req_addr;
  assign databus.databus_len_0   = req_len;
  assign databus.databus_wdata_0 = '0;
  assign databus.databus_wstrb_0 = '0;

  assign wr_addr = {bank_wr, beats_done[ADDR_W-1:0]};
  assign wr_data = DATA_W'(databus.databus_rdata_0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      remaining  <= '0;
      beats_done <= '0;
      burst_len  <= '0;
      burst_cnt  <= '0;
      pp         <= 1'b0;
      bank_wr    <= 1'b0;
      valid      <= 1'b0;
      req_addr   <= '0;
      req_len    <= '0;
      done       <= 1'b1;
    end else begin
      state      <= state_n;
      base       <= base_n;
      remaining  <= remaining_n;
      beats_done <= beats_done_n;
      burst_len  <= burst_len_n;
      burst_cnt  <= burst_cnt_n;
      pp         <= pp_n;
      bank_wr    <= bank_wr_n;
      valid      <= valid_n;
      req_addr   <= req_addr_n;
      req_len    <= req_len_n;
      done       <= done_n;
    end
  end

  // valid is registered: it rises on entry to BEAT and falls right after the
  // last beat, which gives the one-cycle gap before the next REQ.
  always_comb begin
    state_n      = state;
    base_n       = base;
    remaining_n  = remaining;
    beats_done_n = beats_done;
    burst_len_n  = burst_len;
    burst_cnt_n  = burst_cnt;
    pp_n         = pp;
    bank_wr_n    = bank_wr;
    valid_n      = valid;
    req_addr_n   = req_addr;
    req_len_n    = req_len;
    done_n       = done;
    wr_en        = 1'b0;
    swap_en      = 1'b0;
    case (state)
      IDLE: begin
        if (run && !disabled) begin
          base_n       = ext_addr;
          remaining_n  = words_clamped;
          beats_done_n = '0;
          pp_n         = ping_pong;
          bank_wr_n    = ping_pong ? ~bank_rd : bank_rd;
          if (words_clamped != '0) begin
            state_n = REQ;
            done_n  = 1'b0;
          end
        end
      end
      REQ: begin
        valid_n     = 1'b1;
        req_addr_n  = base + AXI_ADDR_W'(beats_done) * BPB_A;
        req_len_n   = LEN_W'(burst_now - ONE);
        burst_len_n = burst_now;
        burst_cnt_n = '0;
        state_n     = BEAT;
      end
      BEAT: begin
        if (databus.databus_ready_0) begin
          wr_en        = 1'b1;
          beats_done_n = beats_done + ONE;
          remaining_n  = remaining - ONE;
          burst_cnt_n  = burst_cnt + ONE;
          if (burst_cnt + ONE == burst_len) begin
            valid_n = 1'b0;
            state_n = (remaining != ONE) ? REQ : SWAP;
          end
        end
      end
      SWAP: begin
        swap_en = pp;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lookup_table_pp_loader.sv
`default_nettype none
// ==== lookup_table_pp_loader : ping-pong lookup table with burst loader ====
// ==== rev 1.0                                                           ====
module lookup_table_pp_loader
  import lut_pp_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  running,
  output logic                  done,
  input  logic [ADDR_W-1:0]     in0,
  input  logic                  in0_valid,
  output logic [DATA_W-1:0]     out0,
  output logic                  out0_valid,
  input  logic [AXI_ADDR_W-1:0] ext_addr,
  input  logic [LEN_W-1:0]      length,
  input  logic                  pingPong,
  input  logic                  disabled,
  lookup_table_pp_loader_if.master databus,
  output logic [ADDR_W:0]       ext_dp_addr_0_port_0,
  output logic [DATA_W-1:0]     ext_dp_out_0_port_0,
  input  logic [DATA_W-1:0]     ext_dp_in_0_port_0,
  output logic                  ext_dp_enable_0_port_0,
  output logic                  ext_dp_write_0_port_0,
  output logic [ADDR_W:0]       ext_dp_addr_0_port_1,
  output logic [DATA_W-1:0]     ext_dp_out_0_port_1,
  input  logic [DATA_W-1:0]     ext_dp_in_0_port_1,
  output logic                  ext_dp_enable_0_port_1,
  output logic                  ext_dp_write_0_port_1
);

  logic bank_rd;
  logic bank_wr;
  logic swap_en;
  logic wr_en;
  logic rd_valid;
  logic unused_inputs;

  assign unused_inputs = ^{running, ext_dp_in_0_port_0};

  lut_burst_loader #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .AXI_ADDR_W (AXI_ADDR_W),
    .AXI_DATA_W (AXI_DATA_W),
    .LEN_W      (LEN_W),
    .MAX_BURST  (MAX_BURST)
  ) u_loader (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .disabled  (disabled),
    .ping_pong (pingPong),
    .bank_rd   (bank_rd),
    .ext_addr  (ext_addr),
    .length    (length),
    .databus   (databus),
    .wr_addr   (ext_dp_addr_0_port_0),
    .wr_data   (ext_dp_out_0_port_0),
    .wr_en     (wr_en),
    .done      (done),
    .bank_wr   (bank_wr),
    .swap_en   (swap_en)
  );

  assign ext_dp_enable_0_port_0 = wr_en;
  assign ext_dp_write_0_port_0  = wr_en;

  // Read address uses the current bank_rd, so a swap committing on the same
  // edge only affects lookups issued afterwards.
  assign ext_dp_addr_0_port_1   = {bank_rd, in0};
  assign ext_dp_enable_0_port_1 = in0_valid;
  assign ext_dp_out_0_port_1    = '0;
  assign ext_dp_write_0_port_1  = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_rd <= 1'b0;
    end else if (swap_en) begin
      bank_rd <= bank_wr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid   <= 1'b0;
      out0_valid <= 1'b0;
      out0       <= '0;
    end else begin
      rd_valid   <= in0_valid;
      out0_valid <= rd_valid;
      if (rd_valid) begin
        out0 <= ext_dp_in_0_port_1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lookup_table_pp_loader.sv
`default_nettype none
// tb_lookup_table_pp_loader: directed vector table plus ping-pong and reset
// sequences, with a bursting memory slave and a dual-port RAM model.
module tb_lookup_table_pp_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        running = 1'b0;
  logic        done;
  logic [3:0]  in0 = '0;
  logic        in0_valid = 1'b0;
  logic [31:0] out0;
  logic        out0_valid;
  logic [31:0] ext_addr = '0;
  logic [7:0]  length = '0;
  logic        pingPong = 1'b0;
  logic        disabled = 1'b0;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1, q0, rd_q;
  logic        en0, we0, en1, we1;

  lookup_table_pp_loader_if #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .LEN_W(8)) bus ();

  lookup_table_pp_loader dut (
    .clk(clk), .rst(rst), .run(run), .running(running), .done(done),
    .in0(in0), .in0_valid(in0_valid), .out0(out0), .out0_valid(out0_valid),
    .ext_addr(ext_addr), .length(length), .pingPong(pingPong), .disabled(disabled),
    .databus(bus),
    .ext_dp_addr_0_port_0(a0), .ext_dp_out_0_port_0(d0), .ext_dp_in_0_port_0(q0),
    .ext_dp_enable_0_port_0(en0), .ext_dp_write_0_port_0(we0),
    .ext_dp_addr_0_port_1(a1), .ext_dp_out_0_port_1(d1), .ext_dp_in_0_port_1(rd_q),
    .ext_dp_enable_0_port_1(en1), .ext_dp_write_0_port_1(we1)
  );

  always #5 clk = ~clk;
  assign q0 = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // RAM model and write bookkeeping
  logic [31:0] ram [0:31];
  int nwrites = 0, nwr_bank1 = 0, wr_err = 0;
  always @(posedge clk) begin
    if (en0 && we0) begin
      ram[a0] <= d0;
      nwrites++;
      if (a0[4]) nwr_bank1++;
      if (!bus.databus_ready_0) wr_err++;
    end
    if (en1) rd_q <= ram[a1];
  end

  // Memory slave: word j of system memory holds sysmem[j]
  logic [31:0] sysmem [0:63];
  logic [31:0] req_addr_q [$];
  logic [7:0]  req_len_q [$];
  logic [31:0] cur_addr = '0;
  logic [7:0]  cur_len = '0;
  logic [31:0] widx;
  logic        prev_valid = 1'b0, acc = 1'b0, rdy;
  int beat_cnt = 0, pidx = 0, stab_err = 0, ready_mode = 0;
  always @(negedge clk) begin
    if (acc) beat_cnt++;
    if (!bus.databus_valid_0) begin
      beat_cnt = 0;
      pidx = 0;
    end
    if (bus.databus_valid_0 && !prev_valid) begin
      cur_addr = bus.databus_addr_0;
      cur_len  = bus.databus_len_0;
      req_addr_q.push_back(cur_addr);
      req_len_q.push_back(cur_len);
    end else if (bus.databus_valid_0 &&
                 (bus.databus_addr_0 !== cur_addr || bus.databus_len_0 !== cur_len)) begin
      stab_err++;
    end
    if (bus.databus_valid_0) begin
      rdy = (ready_mode == 0) || (pidx % 4 == 0) || (pidx % 4 == 3);
      pidx++;
    end else begin
      rdy = 1'b0;
    end
    widx = (cur_addr >> 2) + 32'(beat_cnt);
    bus.databus_ready_0 = rdy;
    bus.databus_rdata_0 = sysmem[widx[5:0]];
    bus.databus_last_0  = 1'b0;
    acc = bus.databus_valid_0 && rdy;
    prev_valid = bus.databus_valid_0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required end before", $time);
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fill(input logic [31:0] tag);
    for (int j = 0; j < 64; j++) sysmem[j] = tag + 32'(j);
  endtask

  task automatic start_load(input logic [31:0] base, input logic [7:0] len,
                            input logic pp, input logic dis);
    ext_addr = base; length = len; pingPong = pp; disabled = dis; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (done !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("%s done", nm), {31'd0, done}, 32'd1);
  endtask

  task automatic lookup(input int idx, input logic [31:0] exp, input string nm);
    in0 = 4'(idx); in0_valid = 1'b1;
    @(negedge clk);
    in0_valid = 1'b0;
    check($sformatf("%s valid@1", nm), {31'd0, out0_valid}, 32'd0);
    @(negedge clk);
    check($sformatf("%s valid@2", nm), {31'd0, out0_valid}, 32'd1);
    check($sformatf("%s data", nm), out0, exp);
    @(negedge clk);
    check($sformatf("%s valid@3", nm), {31'd0, out0_valid}, 32'd0);
    check($sformatf("%s held", nm), out0, exp);
  endtask

  typedef struct {
    logic [31:0] base;
    logic [7:0]  length;
    logic        dis;
    int          tog;
    logic [31:0] tag;
    int          nreq;
    logic [7:0]  len0;
    logic [7:0]  len1;
    int          writes;
  } vec_t;

  vec_t vecs [7];
  int s_req, s_wr, s_b1, s_stab, s_err, k;

  initial begin
    vecs[0] = '{32'h00, 8'd16, 1'b0, 0, 32'h100, 2, 8'd7, 8'd7, 16};
    vecs[1] = '{32'h00, 8'd12, 1'b0, 0, 32'h200, 2, 8'd7, 8'd3, 12};
    vecs[2] = '{32'h00, 8'd40, 1'b0, 0, 32'h300, 2, 8'd7, 8'd7, 16};
    vecs[3] = '{32'h00, 8'd0,  1'b0, 0, 32'h400, 0, 8'd0, 8'd0, 0};
    vecs[4] = '{32'h00, 8'd16, 1'b1, 0, 32'h500, 0, 8'd0, 8'd0, 0};
    vecs[5] = '{32'h40, 8'd5,  1'b0, 0, 32'h600, 1, 8'd4, 8'd0, 5};
    vecs[6] = '{32'h80, 8'd16, 1'b0, 1, 32'h700, 2, 8'd7, 8'd7, 16};

    repeat (3) @(negedge clk);
    check("reset done", {31'd0, done}, 32'd1);
    check("reset valid", {31'd0, bus.databus_valid_0}, 32'd0);
    check("reset addr", bus.databus_addr_0, 32'd0);
    check("reset len", {24'd0, bus.databus_len_0}, 32'd0);
    check("reset wdata", bus.databus_wdata_0, 32'd0);
    check("reset wstrb", {28'd0, bus.databus_wstrb_0}, 32'd0);
    check("reset out0", out0, 32'd0);
    check("reset out0_valid", {31'd0, out0_valid}, 32'd0);
    check("reset port0 en", {30'd0, en0, we0}, 32'd0);
    check("reset port1", {30'd0, en1, we1}, 32'd0);
    check("reset port1 out", d1, 32'd0);
    check("reset bank_rd", {31'd0, dut.bank_rd}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      fill(vecs[v].tag);
      ready_mode = vecs[v].tog;
      s_req = req_addr_q.size(); s_wr = nwrites; s_b1 = nwr_bank1;
      s_stab = stab_err; s_err = wr_err;
      start_load(vecs[v].base, vecs[v].length, 1'b0, vecs[v].dis);
      check($sformatf("v%0d done after run", v), {31'd0, done},
            (vecs[v].writes == 0) ? 32'd1 : 32'd0);
      wait_done($sformatf("v%0d", v));
      repeat (3) @(negedge clk);
      check($sformatf("v%0d nreq", v), 32'(req_addr_q.size() - s_req), 32'(vecs[v].nreq));
      if (vecs[v].nreq >= 1) begin
        check($sformatf("v%0d addr0", v), req_addr_q[s_req], vecs[v].base);
        check($sformatf("v%0d len0", v), {24'd0, req_len_q[s_req]}, {24'd0, vecs[v].len0});
      end
      if (vecs[v].nreq >= 2) begin
        check($sformatf("v%0d addr1", v), req_addr_q[s_req+1], vecs[v].base + 32'h20);
        check($sformatf("v%0d len1", v), {24'd0, req_len_q[s_req+1]}, {24'd0, vecs[v].len1});
      end
      check($sformatf("v%0d writes", v), 32'(nwrites - s_wr), 32'(vecs[v].writes));
      check($sformatf("v%0d bank1 writes", v), 32'(nwr_bank1 - s_b1), 32'd0);
      check($sformatf("v%0d addr/len stable", v), 32'(stab_err - s_stab), 32'd0);
      check($sformatf("v%0d write w/o ready", v), 32'(wr_err - s_err), 32'd0);
      if (vecs[v].writes > 0) begin
        lookup(vecs[v].writes - 1,
               vecs[v].tag + (vecs[v].base >> 2) + 32'(vecs[v].writes - 1),
               $sformatf("v%0d lk last", v));
        lookup(5 % vecs[v].writes,
               vecs[v].tag + (vecs[v].base >> 2) + 32'(5 % vecs[v].writes),
               $sformatf("v%0d lk mid", v));
      end
    end

    // Ping-pong: table A lands in bank 1 and becomes live
    ready_mode = 0;
    fill(32'hA0);
    s_b1 = nwr_bank1;
    start_load(32'h0, 8'd16, 1'b1, 1'b0);
    wait_done("ppA");
    repeat (3) @(negedge clk);
    check("ppA bank_rd", {31'd0, dut.bank_rd}, 32'd1);
    check("ppA bank1 writes", 32'(nwr_bank1 - s_b1), 32'd16);
    lookup(3, 32'hA3, "ppA lk3");

    // Table B loads into bank 0 while lookups keep reading A
    fill(32'hB0);
    ready_mode = 1;
    s_b1 = nwr_bank1; s_wr = nwrites;
    start_load(32'h0, 8'd16, 1'b1, 1'b0);
    in0 = 4'd3; in0_valid = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j >= 1) begin
        check($sformatf("ppB busy lk%0d valid", j), {31'd0, out0_valid}, 32'd1);
        check($sformatf("ppB busy lk%0d data", j), out0, 32'hA3);
      end
    end
    in0_valid = 1'b0;
    check("ppB still loading", {31'd0, done}, 32'd0);
    wait_done("ppB");
    repeat (3) @(negedge clk);
    check("ppB bank_rd", {31'd0, dut.bank_rd}, 32'd0);
    check("ppB writes", 32'(nwrites - s_wr), 32'd16);
    check("ppB bank1 writes", 32'(nwr_bank1 - s_b1), 32'd0);
    lookup(3, 32'hB3, "ppB lk3");

    // Reset in the middle of a burst
    ready_mode = 0;
    fill(32'hD00);
    start_load(32'h0, 8'd16, 1'b1, 1'b0);
    wait_done("ppD");
    repeat (3) @(negedge clk);
    check("ppD bank_rd", {31'd0, dut.bank_rd}, 32'd1);
    fill(32'hE00);
    s_wr = nwrites;
    start_load(32'h0, 8'd16, 1'b1, 1'b0);
    k = 0;
    while (!((nwrites - s_wr) == 2 && bus.databus_valid_0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rst at beat3", 32'(nwrites - s_wr), 32'd2);
    rst = 1'b1;
    #1;
    check("rst valid", {31'd0, bus.databus_valid_0}, 32'd0);
    check("rst done", {31'd0, done}, 32'd1);
    check("rst bank_rd", {31'd0, dut.bank_rd}, 32'd0);
    check("rst port0 en", {31'd0, en0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst no more writes", 32'(nwrites - s_wr), 32'd2);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    fill(32'hF00);
    s_req = req_addr_q.size(); s_wr = nwrites; s_b1 = nwr_bank1;
    start_load(32'h0, 8'd16, 1'b0, 1'b0);
    wait_done("post-rst");
    repeat (3) @(negedge clk);
    check("post-rst nreq", 32'(req_addr_q.size() - s_req), 32'd2);
    check("post-rst writes", 32'(nwrites - s_wr), 32'd16);
    check("post-rst bank1 writes", 32'(nwr_bank1 - s_b1), 32'd0);
    check("post-rst bank_rd", {31'd0, dut.bank_rd}, 32'd0);
    lookup(7, 32'hF07, "post-rst lk7");
    lookup(15, 32'hF0F, "post-rst lk15");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
